sram_bus_arbiter: RTL and testbench
===================================

SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high; no parameters.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 inst_sram_req  in  1  core instruction read request (read-only port).
REQ-005 inst_sram_addr  in  32  instruction byte address.
REQ-006 inst_sram_addr_ok  out  1  instruction request accepted this cycle.
REQ-007 inst_sram_data_ok  out  1  instruction read data valid, one-cycle pulse.
REQ-008 inst_sram_rdata  out  32  instruction read data.
REQ-009 data_sram_req  in  1  core data request.
REQ-010 data_sram_wr  in  1  1 = write, 0 = read.
REQ-011 data_sram_size  in  2  0 = byte, 1 = half, 2 = word.
REQ-012 data_sram_wstrb  in  4  write byte enables.
REQ-013 data_sram_addr  in  32  data byte address.
REQ-014 data_sram_wdata  in  32  write data.
REQ-015 data_sram_addr_ok  out  1  data request accepted this cycle.
REQ-016 data_sram_data_ok  out  1  data transaction complete, one-cycle pulse; write completions included.
REQ-017 data_sram_rdata  out  32  data read data.
REQ-018 bus_req  out  1  downstream request, held until granted.
REQ-019 bus_wr  out  1  downstream write flag.
REQ-020 bus_size  out  2  downstream size.
REQ-021 bus_addr  out  32  downstream address.
REQ-022 bus_wstrb  out  4  downstream byte enables.
REQ-023 bus_wdata  out  32  downstream write data.
REQ-024 bus_gnt  in  1  downstream accepted request this cycle.
REQ-025 bus_rvalid  in  1  downstream response, one per granted request (reads and writes).
REQ-026 bus_rdata  in  32  downstream read data.

Function
REQ-027 FSM states SHALL be IDLE, REQ and RESP; the block SHALL have at most one outstanding transaction.
REQ-028 In IDLE, addr_ok SHALL be combinational: data_sram_addr_ok = data_sram_req; inst_sram_addr_ok = inst_sram_req & ~data_sram_req. Both SHALL be 0 outside IDLE.
REQ-029 Simultaneous inst and data requests in IDLE SHALL resolve to data; the inst request SHALL wait with no ack.
REQ-030 On an addr_ok cycle, the block SHALL latch owner, wr, size, addr, wstrb and wdata, then go IDLE->REQ. Inst requests latch as wr=0, size=2, wstrb=0.
REQ-031 In REQ, bus_req SHALL be 1 with the latched fields; bus_req SHALL be 0 in IDLE and RESP; bus_gnt SHALL move REQ->RESP.
REQ-032 In RESP, bus_rvalid SHALL pulse the owner's data_ok for that same cycle, with owner rdata = bus_rdata, and SHALL move RESP->IDLE.
REQ-033 bus_rvalid outside RESP and bus_gnt outside REQ SHALL be ignored.
REQ-034 Minimum latency SHALL be 3 cycles: addr_ok at cycle 0, bus_req at cycle 1, earliest data_ok at cycle 2 when bus_gnt arrives at cycle 1 and bus_rvalid at cycle 2.
REQ-035 Back-to-back: a new addr_ok SHALL be possible in the cycle after data_ok.
REQ-036 data_sram_size=3 SHALL be forwarded as 2.
REQ-037 rdata outputs SHALL hold their last value when data_ok=0.

Reset
REQ-038 Reset SHALL force IDLE and all outputs to 0, and clear the latched fields to 0, asynchronously and mid-transaction. An in-flight bus response arriving after reset SHALL be discarded per REQ-033.

Structure
REQ-039 FSM state encoding and size constants SHALL live in the shared package; owner select and FSM SHALL be a single module with no sub-modules.

Verification
REQ-040 Inst read 0x1c000000; gnt at +1, rvalid at +2 with 0x02800400 -> inst_sram_data_ok at cycle 2 with rdata 0x02800400.
REQ-041 Inst and data reads in the same cycle -> data_sram_addr_ok=1 and inst_sram_addr_ok=0; inst accepted the cycle after data's data_ok.
REQ-042 Data write addr 0x8, wstrb 0x3, wdata 0xdeadbeef, gnt delayed 4 cycles -> bus_req held with constant fields for 4 cycles; data_ok on rvalid.
REQ-043 Reset asserted in RESP, then stray bus_rvalid -> no data_ok; state IDLE.
REQ-044 data_sram_size=3 -> bus_size=2.
REQ-045 Back-to-back data reads -> second data_sram_addr_ok in the cycle after the first data_ok.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the SRAM-to-bus arbiter.
package sram_bus_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned SIZE_W = 2;

   localparam logic [SIZE_W-1:0] SIZE_BYTE = SIZE_W'(0);
   localparam logic [SIZE_W-1:0] SIZE_HALF = SIZE_W'(1);
   localparam logic [SIZE_W-1:0] SIZE_WORD = SIZE_W'(2);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef enum logic {
      OWNER_INST = 1'b0,
      OWNER_DATA = 1'b1
   } owner_e;

   // Latched downstream request payload
   typedef struct packed {
      logic              wr;
      logic [SIZE_W-1:0] size;
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] wstrb;
      logic [DATA_W-1:0] wdata;
   } bus_txn_t;

   // The bus has no encoding above word; the reserved size code maps to word
   function automatic logic [SIZE_W-1:0] norm_size(input logic [SIZE_W-1:0] size);
      return (size == SIZE_W'(3)) ? SIZE_WORD : size;
   endfunction

endpackage

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the core's instruction and data SRAM-like ports onto one
// downstream bus, one transaction in flight, data port has priority.
module sram_bus_arbiter
   import sram_bus_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset,

   input  logic              inst_sram_req,
   input  logic [ADDR_W-1:0] inst_sram_addr,
   output logic              inst_sram_addr_ok,
   output logic              inst_sram_data_ok,
   output logic [DATA_W-1:0] inst_sram_rdata,

   input  logic              data_sram_req,
   input  logic              data_sram_wr,
   input  logic [SIZE_W-1:0] data_sram_size,
   input  logic [STRB_W-1:0] data_sram_wstrb,
   input  logic [ADDR_W-1:0] data_sram_addr,
   input  logic [DATA_W-1:0] data_sram_wdata,
   output logic              data_sram_addr_ok,
   output logic              data_sram_data_ok,
   output logic [DATA_W-1:0] data_sram_rdata,

   output logic              bus_req,
   output logic              bus_wr,
   output logic [SIZE_W-1:0] bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [STRB_W-1:0] bus_wstrb,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [DATA_W-1:0] bus_rdata
);

   state_e            state;
   owner_e            owner;
   bus_txn_t          txn;
   logic [DATA_W-1:0] inst_rdata_q;
   logic [DATA_W-1:0] data_rdata_q;
   logic              idle;
   logic              resp_fire;

   assign idle      = (state == ST_IDLE) && !reset;
   assign resp_fire = (state == ST_RESP) && bus_rvalid;

   // Acceptance is same-cycle; data wins a tie, inst sees no ack
   assign data_sram_addr_ok = idle && data_sram_req;
   assign inst_sram_addr_ok = idle && inst_sram_req && !data_sram_req;

   // Completion is same-cycle with the bus response; rdata holds between pulses
   assign data_sram_data_ok = resp_fire && (owner == OWNER_DATA);
   assign inst_sram_data_ok = resp_fire && (owner == OWNER_INST);
   assign data_sram_rdata   = data_sram_data_ok ? bus_rdata : data_rdata_q;
   assign inst_sram_rdata   = inst_sram_data_ok ? bus_rdata : inst_rdata_q;

   // Downstream request is presented only while waiting for grant
   assign bus_req   = (state == ST_REQ);
   assign bus_wr    = txn.wr;
   assign bus_size  = txn.size;
   assign bus_addr  = txn.addr;
   assign bus_wstrb = txn.wstrb;
   assign bus_wdata = txn.wdata;

   // Control FSM: latch the winning request, wait for grant, wait for response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         owner        <= OWNER_INST;
         txn          <= '0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (data_sram_req) begin
                  owner     <= OWNER_DATA;
                  txn.wr    <= data_sram_wr;
                  txn.size  <= norm_size(data_sram_size);
                  txn.addr  <= data_sram_addr;
                  txn.wstrb <= data_sram_wstrb;
                  txn.wdata <= data_sram_wdata;
                  state     <= ST_REQ;
               end else if (inst_sram_req) begin
                  owner     <= OWNER_INST;
                  txn.wr    <= 1'b0;
                  txn.size  <= SIZE_WORD;
                  txn.addr  <= inst_sram_addr;
                  txn.wstrb <= '0;
                  txn.wdata <= '0;
                  state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (bus_gnt) begin
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus_rvalid) begin
                  if (owner == OWNER_DATA) begin
                     data_rdata_q <= bus_rdata;
                  end else begin
                     inst_rdata_q <= bus_rdata;
                  end
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter: directed scenarios then random traffic.
module tb_sram_bus_arbiter;

   logic        clk;
   logic        reset;
   logic        inst_sram_req;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   sram_bus_arbiter dut (
      .clk               (clk),
      .reset             (reset),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_size    (data_sram_size),
      .data_sram_wstrb   (data_sram_wstrb),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .bus_req           (bus_req),
      .bus_wr            (bus_wr),
      .bus_size          (bus_size),
      .bus_addr          (bus_addr),
      .bus_wstrb         (bus_wstrb),
      .bus_wdata         (bus_wdata),
      .bus_gnt           (bus_gnt),
      .bus_rvalid        (bus_rvalid),
      .bus_rdata         (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected transaction as seen by the core/bus (transaction-level model)
   typedef struct {
      bit          is_data;
      bit          wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } txn_t;

   txn_t        sb_q[$];
   int          phase;          // 0 nothing in flight, 1 awaiting grant, 2 awaiting response
   logic [31:0] exp_inst_rdata;
   logic [31:0] exp_data_rdata;
   int          cyc;
   int          accept_cyc;
   int          done_cyc;
   int          last_lat;
   int          n_vec;
   int          n_err;

   initial begin
      cyc = 0; accept_cyc = 0; done_cyc = 0; last_lat = 0;
      n_vec = 0; n_err = 0; phase = 0;
      exp_inst_rdata = '0; exp_data_rdata = '0;
   end

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every output against the model mid-cycle, then advances the model
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_data_addr_ok", 32'(data_sram_addr_ok), 32'd0);
         chk("rst_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
         chk("rst_data_ok", 32'(data_sram_data_ok), 32'd0);
         chk("rst_inst_ok", 32'(inst_sram_data_ok), 32'd0);
         chk("rst_bus_req", 32'(bus_req), 32'd0);
         chk("rst_bus_addr", bus_addr, 32'd0);
         chk("rst_data_rdata", data_sram_rdata, 32'd0);
         chk("rst_inst_rdata", inst_sram_rdata, 32'd0);
         sb_q.delete();
         phase = 0;
         exp_inst_rdata = '0;
         exp_data_rdata = '0;
      end else begin
         bit e_daok, e_iaok, e_dok, e_iok;
         txn_t t;
         e_daok = (phase == 0) && data_sram_req;
         e_iaok = (phase == 0) && inst_sram_req && !data_sram_req;
         chk("data_addr_ok", 32'(data_sram_addr_ok), 32'(e_daok));
         chk("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(e_iaok));
         chk("bus_req", 32'(bus_req), 32'(phase == 1));
         if (phase == 1 && sb_q.size() > 0) begin
            t = sb_q[0];
            chk("bus_wr", 32'(bus_wr), 32'(t.wr));
            chk("bus_size", 32'(bus_size), 32'(t.size));
            chk("bus_addr", bus_addr, t.addr);
            chk("bus_wstrb", 32'(bus_wstrb), 32'(t.wstrb));
            if (t.is_data) chk("bus_wdata", bus_wdata, t.wdata);
         end
         e_dok = (phase == 2) && bus_rvalid && sb_q.size() > 0 && sb_q[0].is_data;
         e_iok = (phase == 2) && bus_rvalid && sb_q.size() > 0 && !sb_q[0].is_data;
         chk("data_ok", 32'(data_sram_data_ok), 32'(e_dok));
         chk("inst_ok", 32'(inst_sram_data_ok), 32'(e_iok));
         if (e_dok) exp_data_rdata = bus_rdata;
         if (e_iok) exp_inst_rdata = bus_rdata;
         chk("data_rdata", data_sram_rdata, exp_data_rdata);
         chk("inst_rdata", inst_sram_rdata, exp_inst_rdata);
         if (phase == 2 && bus_rvalid) begin
            void'(sb_q.pop_front());
            last_lat = cyc - accept_cyc;
            done_cyc = cyc;
            phase = 0;
         end else if (phase == 1 && bus_gnt) begin
            phase = 2;
         end else if (e_daok || e_iaok) begin
            t.is_data = e_daok;
            t.wr      = e_daok ? data_sram_wr : 1'b0;
            t.size    = e_daok ? ((data_sram_size == 2'd3) ? 2'd2 : data_sram_size) : 2'd2;
            t.addr    = e_daok ? data_sram_addr : inst_sram_addr;
            t.wstrb   = e_daok ? data_sram_wstrb : 4'h0;
            t.wdata   = data_sram_wdata;
            sb_q.push_back(t);
            accept_cyc = cyc;
            phase = 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      inst_sram_req = 0; inst_sram_addr = '0;
      data_sram_req = 0; data_sram_wr = 0; data_sram_size = '0;
      data_sram_wstrb = '0; data_sram_addr = '0; data_sram_wdata = '0;
      bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
   endtask

   task automatic data_rd(input logic [31:0] a, input logic [1:0] sz);
      data_sram_req = 1; data_sram_wr = 0; data_sram_addr = a; data_sram_size = sz;
      data_sram_wstrb = '0; data_sram_wdata = '0;
   endtask

   initial begin
      reset = 1'b1;
      quiet();
      repeat (2) step();
      reset = 1'b0;
      step();

      // Single instruction read at minimum latency
      inst_sram_req = 1; inst_sram_addr = 32'h1c000000;
      step();
      quiet(); bus_gnt = 1;
      step();
      quiet(); bus_rvalid = 1; bus_rdata = 32'h02800400;
      #3 chk("inst_fetch_rdata", inst_sram_rdata, 32'h02800400);
      step();
      quiet();
      chk("inst_fetch_latency", 32'(last_lat), 32'd2);
      step();

      // Simultaneous requests: data first, inst waits then follows
      inst_sram_req = 1; inst_sram_addr = 32'h1c000010;
      data_rd(32'h00001000, 2'd2);
      step();
      data_sram_req = 0; bus_gnt = 1;
      step();
      bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h11112222;
      step();
      bus_rvalid = 0;
      step();
      inst_sram_req = 0; bus_gnt = 1;
      step();
      bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h33334444;
      step();
      quiet();
      step();

      // Write with grant delayed four cycles
      data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h8;
      data_sram_size = 2'd2; data_sram_wstrb = 4'h3; data_sram_wdata = 32'hdeadbeef;
      step();
      quiet();
      repeat (4) step();
      bus_gnt = 1;
      step();
      quiet(); bus_rvalid = 1; bus_rdata = 32'h0;
      step();
      quiet();
      step();

      // Reserved size code is forwarded as word
      data_rd(32'h00002000, 2'd3);
      step();
      quiet();
      chk("size3_forwarded", 32'(bus_size), 32'd2);
      bus_gnt = 1;
      step();
      quiet(); bus_rvalid = 1; bus_rdata = 32'h55667788;
      step();
      quiet();
      step();

      // Back-to-back data reads
      data_rd(32'h00003000, 2'd1);
      step();
      quiet(); bus_gnt = 1;
      step();
      bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h99aabbcc;
      data_rd(32'h00003004, 2'd0);
      step();
      bus_rvalid = 0;
      step();
      chk("b2b_gap", 32'(accept_cyc - done_cyc), 32'd1);
      quiet(); bus_gnt = 1;
      step();
      quiet(); bus_rvalid = 1; bus_rdata = 32'h0badf00d;
      step();
      quiet();
      step();

      // Reset while waiting for the response, then a stray response
      data_rd(32'h00004000, 2'd2);
      step();
      quiet(); bus_gnt = 1;
      step();
      quiet();
      #2 reset = 1'b1;
      #1;
      chk("midrst_bus_req", 32'(bus_req), 32'd0);
      chk("midrst_data_ok", 32'(data_sram_data_ok), 32'd0);
      step();
      reset = 1'b0;
      bus_rvalid = 1; bus_rdata = 32'hfeedface;
      #1 chk("stray_rvalid_ignored", 32'(data_sram_data_ok), 32'd0);
      data_sram_req = 1;
      #1 chk("idle_after_rst", 32'(data_sram_addr_ok), 32'd1);
      step();
      quiet();
      bus_gnt = 1;
      step();
      quiet(); bus_rvalid = 1; bus_rdata = 32'h12345678;
      step();
      quiet();
      step();

      // Random traffic including stray grants/responses and occasional resets
      for (int i = 0; i < 800; i++) begin
         reset           = ($urandom_range(0, 199) == 0);
         inst_sram_req   = ($urandom_range(0, 2) == 0);
         inst_sram_addr  = $urandom & 32'hfffffffc;
         data_sram_req   = ($urandom_range(0, 3) == 0);
         data_sram_wr    = 1'($urandom_range(0, 1));
         data_sram_size  = 2'($urandom_range(0, 3));
         data_sram_wstrb = 4'($urandom);
         data_sram_addr  = $urandom;
         data_sram_wdata = $urandom;
         bus_gnt         = 1'($urandom_range(0, 1));
         bus_rvalid      = ($urandom_range(0, 2) == 0);
         bus_rdata       = $urandom;
         step();
      end
      reset = 1'b0;
      quiet();
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
